// File: rtl/bound_flasher_ctrl_if.sv
// Flasher control bundle: flick/pause requests in, lamp count and status out.
// The pause wire exists only when BF_CTRL_PAUSE_EN is defined.
interface bound_flasher_ctrl_if #(
  parameter int N_LAMPS = 16,
  parameter int CW      = $clog2(N_LAMPS + 1)
);
  logic               flick;
`ifdef BF_CTRL_PAUSE_EN
  logic               pause;
`endif
  logic [CW-1:0]      counter;
  logic [N_LAMPS-1:0] lamps;
  logic [2:0]         state;
  logic               busy;
  logic               done;

  modport master (
`ifdef BF_CTRL_PAUSE_EN
    output pause,
`endif
    output flick,
    input  counter,
    input  lamps,
    input  state,
    input  busy,
    input  done
  );

  modport slave (
`ifdef BF_CTRL_PAUSE_EN
    input  pause,
`endif
    input  flick,
    output counter,
    output lamps,
    output state,
    output busy,
    output done
  );
endinterface

// File: rtl/bound_flasher_ctrl.sv
// Bound flasher: three up/down ramps with flick-triggered kickback descents.
// Optional step freeze input enabled by defining BF_CTRL_PAUSE_EN.
module bound_flasher_ctrl #(
  parameter int N_LAMPS  = 16,
  parameter int MID_LO   = 5,
  parameter int MID_HI   = 10,
  parameter int STEP_DIV = 1
) (
  input logic                 clk,
  input logic                 rst,
  bound_flasher_ctrl_if.slave bus
);
  localparam int CW = $clog2(N_LAMPS + 1);
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] UP_A = 3'd1;
  localparam logic [2:0] DN_A = 3'd2;
  localparam logic [2:0] UP_B = 3'd3;
  localparam logic [2:0] DN_B = 3'd4;
  localparam logic [2:0] UP_C = 3'd5;
  localparam logic [2:0] DN_C = 3'd6;
  localparam logic [2:0] KB   = 3'd7;

  localparam logic [CW-1:0] LO   = CW'(MID_LO);
  localparam logic [CW-1:0] HI   = CW'(MID_HI);
  localparam logic [CW-1:0] TOP  = CW'(N_LAMPS);
  localparam logic [PW-1:0] PMAX = PW'(STEP_DIV - 1);

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [CW-1:0] counter;
  logic [CW-1:0] counter_n;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_n;
  logic          done;
  logic          done_n;
  logic [2:0]    ret_state;
  logic [2:0]    ret_state_n;
  logic [CW-1:0] ret_floor;
  logic [CW-1:0] ret_floor_n;

  logic          hold;
  logic          busy;
  logic          tick;
  logic          kick;
  logic          is_idle;
  logic          is_up;
  logic          is_dn;
  logic          is_kb;
  logic [CW-1:0] up_tgt;
  logic [CW-1:0] up_floor;
  logic [CW-1:0] dn_tgt;
  logic [2:0]    adv;

`ifdef BF_CTRL_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign tick = busy && !hold && (presc == PMAX);

  assign is_idle = (state == IDLE);
  assign is_kb   = (state == KB);
  assign is_up   = (state == UP_A) || (state == UP_B) || (state == UP_C);
  assign is_dn   = (state == DN_A) || (state == DN_B) || (state == DN_C);

  always_comb begin
    up_tgt   = TOP;
    up_floor = '0;
    dn_tgt   = '0;
    adv      = IDLE;
    unique case (state)
      UP_A: begin
        up_tgt = HI;
        adv    = DN_A;
      end
      UP_B: adv = DN_B;
      UP_C: begin
        up_floor = LO;
        adv      = DN_C;
      end
      DN_A: adv = UP_B;
      DN_B: begin
        dn_tgt = LO;
        adv    = UP_C;
      end
      default: adv = IDLE;
    endcase
  end

  // Kickback only from a mid point that is above the current ramp's floor.
  assign kick = bus.flick
             && ((counter == LO) || (counter == HI))
             && (counter != up_floor);

  always_comb begin
    if (!busy)
      presc_n = '0;
    else if (hold)
      presc_n = presc;
    else if (presc == PMAX)
      presc_n = '0;
    else
      presc_n = presc + 1'b1;
  end

  always_comb begin
    state_n     = state;
    counter_n   = counter;
    ret_state_n = ret_state;
    ret_floor_n = ret_floor;
    done_n      = 1'b0;
    unique case (1'b1)
      is_idle: begin
        if (bus.flick && !hold)
          state_n = UP_A;
      end
      is_up: begin
        if (tick && kick) begin
          ret_state_n = state;
          ret_floor_n = up_floor;
          state_n     = KB;
          counter_n   = counter - 1'b1;
        end else if (tick && counter != TOP) begin
          counter_n = counter + 1'b1;
          if (counter_n == up_tgt)
            state_n = adv;
        end
      end
      is_dn: begin
        if (tick && counter != '0) begin
          counter_n = counter - 1'b1;
          if (counter_n == dn_tgt) begin
            state_n = adv;
            done_n  = (state == DN_C);
          end
        end
      end
      is_kb: begin
        if (tick) begin
          if (counter == ret_floor) begin
            state_n = ret_state;
          end else begin
            counter_n = counter - 1'b1;
            if (counter_n == ret_floor)
              state_n = ret_state;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      presc     <= '0;
      done      <= 1'b0;
      ret_state <= IDLE;
      ret_floor <= '0;
    end else begin
      state     <= state_n;
      counter   <= counter_n;
      presc     <= presc_n;
      done      <= done_n;
      ret_state <= ret_state_n;
      ret_floor <= ret_floor_n;
    end
  end

  assign bus.counter = counter;
  assign bus.state   = state;
  assign bus.busy    = busy;
  assign bus.done    = done;

  for (genvar i = 0; i < N_LAMPS; i++) begin : g_lamp
    assign bus.lamps[i] = (CW'(i) < counter);
  end
endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Directed bench for bound_flasher_ctrl: full run, kickbacks, reset,
// STEP_DIV=3 timing, and pause when BF_CTRL_PAUSE_EN is defined.
module tb_bound_flasher_ctrl;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   ticks;

  bound_flasher_ctrl_if #(.N_LAMPS(16)) b0 ();
  bound_flasher_ctrl_if #(.N_LAMPS(16)) b1 ();

  bound_flasher_ctrl #(
    .N_LAMPS(16), .MID_LO(5), .MID_HI(10), .STEP_DIV(1)
  ) u0 (
    .clk(clk),
    .rst(rst),
    .bus(b0.slave)
  );

  bound_flasher_ctrl #(
    .N_LAMPS(16), .MID_LO(5), .MID_HI(10), .STEP_DIV(3)
  ) u1 (
    .clk(clk),
    .rst(rst),
    .bus(b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] therm(input int c);
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < c; i++) t[i] = 1'b1;
    return t;
  endfunction

  task automatic seg(input int from, input int to,
                     input int st, input int nst);
    int c;
    c = from;
    while (c != to) begin
      c = (to > from) ? c + 1 : c - 1;
      step();
      ticks++;
      chk("counter", 32'(b0.counter), c);
      chk("state", 32'(b0.state), (c == to) ? nst : st);
      chk("lamps", 32'(b0.lamps), therm(c));
    end
  endtask

  initial begin
    int n;
    n_tests  = 0;
    n_fail   = 0;
    ticks    = 0;
    rst      = 1'b1;
    b0.flick = 1'b0;
    b1.flick = 1'b0;
`ifdef BF_CTRL_PAUSE_EN
    b0.pause = 1'b0;
    b1.pause = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    chk("rst_state", 32'(b0.state), 0);
    chk("rst_counter", 32'(b0.counter), 0);
    chk("rst_busy", 32'(b0.busy), 0);
    chk("rst_done", 32'(b0.done), 0);
    chk("rst_lamps", 32'(b0.lamps), 0);
    for (int i = 0; i < 3; i++) step();
    chk("idle_no_flick", 32'(b0.state), 0);

    // full run
    b0.flick = 1'b1;
    step();
    b0.flick = 1'b0;
    chk("start_state", 32'(b0.state), 1);
    chk("start_counter", 32'(b0.counter), 0);
    chk("start_busy", 32'(b0.busy), 1);
    ticks = 0;
    seg(0, 10, 1, 2);
    seg(10, 0, 2, 3);
    seg(0, 16, 3, 4);
    seg(16, 5, 4, 5);
    seg(5, 16, 5, 6);
    seg(16, 0, 6, 0);
    chk("full_ticks", ticks, 74);
    chk("full_done", 32'(b0.done), 1);
    chk("full_busy", 32'(b0.busy), 0);
    step();
    chk("done_once", 32'(b0.done), 0);
    chk("end_idle", 32'(b0.state), 0);

    // kickbacks in UP_B and UP_C
    b0.flick = 1'b1;
    step();
    b0.flick = 1'b0;
    seg(0, 10, 1, 2);
    seg(10, 0, 2, 3);
    seg(0, 10, 3, 3);
    b0.flick = 1'b1;
    step();
    b0.flick = 1'b0;
    chk("kb_b_state", 32'(b0.state), 7);
    chk("kb_b_counter", 32'(b0.counter), 9);
    seg(9, 0, 7, 3);
    seg(0, 16, 3, 4);
    seg(16, 5, 4, 5);
    b0.flick = 1'b1;
    step();
    b0.flick = 1'b0;
    chk("floor_ign_state", 32'(b0.state), 5);
    chk("floor_ign_counter", 32'(b0.counter), 6);
    seg(6, 10, 5, 5);
    b0.flick = 1'b1;
    step();
    b0.flick = 1'b0;
    chk("kb_c_state", 32'(b0.state), 7);
    chk("kb_c_counter", 32'(b0.counter), 9);
    seg(9, 5, 7, 5);
    seg(5, 16, 5, 6);
    b0.flick = 1'b1;
    seg(16, 0, 6, 0);
    chk("hold_done", 32'(b0.done), 1);
    step();
    b0.flick = 1'b0;
    chk("restart_state", 32'(b0.state), 1);
    chk("restart_done", 32'(b0.done), 0);
    chk("restart_counter", 32'(b0.counter), 0);

    // reset mid DN_B
    seg(0, 10, 1, 2);
    seg(10, 0, 2, 3);
    seg(0, 16, 3, 4);
    seg(16, 12, 4, 4);
    rst = 1'b1;
    b0.flick = 1'b1;
    step();
    rst = 1'b0;
    b0.flick = 1'b0;
    chk("mid_rst_state", 32'(b0.state), 0);
    chk("mid_rst_counter", 32'(b0.counter), 0);
    chk("mid_rst_done", 32'(b0.done), 0);
    chk("mid_rst_busy", 32'(b0.busy), 0);
    step();
    step();
    chk("post_rst_idle", 32'(b0.state), 0);

`ifdef BF_CTRL_PAUSE_EN
    b0.flick = 1'b1;
    b0.pause = 1'b1;
    step();
    chk("pause_blk_start", 32'(b0.state), 0);
    b0.pause = 1'b0;
    step();
    b0.flick = 1'b0;
    seg(0, 7, 1, 1);
    b0.pause = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("pause_counter", 32'(b0.counter), 7);
    chk("pause_state", 32'(b0.state), 1);
    b0.pause = 1'b0;
    step();
    chk("resume_counter", 32'(b0.counter), 8);
    b0.pause = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    b0.pause = 1'b0;
    chk("pause_rst_state", 32'(b0.state), 0);
    chk("pause_rst_counter", 32'(b0.counter), 0);
`endif

    // STEP_DIV=3 timing
    b1.flick = 1'b1;
    step();
    b1.flick = 1'b0;
    n = 1;
    step();
    n++;
    chk("div3_c0a", 32'(b1.counter), 0);
    step();
    n++;
    chk("div3_c0b", 32'(b1.counter), 0);
    step();
    n++;
    chk("div3_c1", 32'(b1.counter), 1);
    while (!b1.done && n < 400) begin
      step();
      n++;
    end
    chk("div3_done", 32'(b1.done), 1);
    chk("div3_cycles", n, 223);
    step();
    chk("div3_done_pulse", 32'(b1.done), 0);
    chk("div3_idle", 32'(b1.state), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bound_flasher_ctrl.md
BOUND_FLASHER_CTRL -- requirements
Module: bound_flasher_ctrl

Interface
REQ-001 SHALL have parameter N_LAMPS, default 16: lamp count; legal range N_LAMPS >= 3.
REQ-002 SHALL have parameter MID_LO, default 5: low kickback point and floor; legal range 0 < MID_LO < MID_HI.
REQ-003 SHALL have parameter MID_HI, default 10: high kickback point; legal range MID_HI < N_LAMPS.
REQ-004 SHALL have parameter STEP_DIV, default 1: clock cycles per count step; legal range >= 1.
REQ-005 SHALL define CW = $clog2(N_LAMPS+1).
REQ-006 clk  in  1  sole clock; one clock; all state on rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 flick  in  1  start request and kickback request.
REQ-009 pause  in  1  step freeze; port exists only with BF_CTRL_PAUSE_EN.
REQ-010 counter  out  CW  number of lit lamps, registered.
REQ-011 lamps  out  N_LAMPS  thermometer view: lamps[i] = (i < counter), combinational from counter.
REQ-012 state  out  3  current FSM state encoding.
REQ-013 busy  out  1  high when state != IDLE.
REQ-014 done  out  1  one-cycle completion pulse, registered.

Function
REQ-015 States and encodings SHALL be: IDLE=0, UP_A=1 (0->MID_HI), DN_A=2 (MID_HI->0), UP_B=3 (0->N_LAMPS), DN_B=4 (N_LAMPS->MID_LO), UP_C=5 (MID_LO->N_LAMPS), DN_C=6 (N_LAMPS->0), KB=7 (kickback descent).
REQ-016 IDLE: counter SHALL stay 0; flick=1 SHALL move state to UP_A on the next edge, with counter unchanged.
REQ-017 The prescaler SHALL count 0..STEP_DIV-1 while busy; tick = busy && prescaler == STEP_DIV-1.
REQ-018 The prescaler SHALL clear on entering IDLE; with STEP_DIV=1, tick SHALL be high every busy cycle.
REQ-019 On tick in an UP state, counter SHALL increment by 1; in a DN state or KB, it SHALL decrement by 1.
REQ-020 When the updated counter equals the state target, the state SHALL advance on the same edge: UP_A->DN_A->UP_B->DN_B->UP_C->DN_C->IDLE.
REQ-021 Floors SHALL be: UP_A=0, UP_B=0, UP_C=MID_LO.
REQ-022 Kickback trigger: tick in an UP state, flick=1, counter in {MID_LO, MID_HI}, and counter != floor.
REQ-023 On kickback the FSM SHALL save the return state and floor, enter KB, and decrement counter on that edge.
REQ-024 A kickback condition with counter == floor SHALL be ignored; normal increment SHALL proceed.
REQ-025 KB: on tick, counter SHALL decrement; on reaching the saved floor, state SHALL return to the saved UP state on the same edge.
REQ-026 flick SHALL be ignored in DN states and in KB; a repeat kickback is allowed after return.
REQ-027 counter SHALL never exceed N_LAMPS and never wrap below 0.
REQ-028 done SHALL be 1 for exactly the first IDLE cycle after DN_C->IDLE; otherwise 0.
REQ-029 flick held high across DN_C->IDLE SHALL restart UP_A one cycle after done.

Reset
REQ-030 rst=1 SHALL force on the next edge: state IDLE, counter 0, prescaler 0, done 0, saved return state and floor 0.
REQ-031 rst SHALL dominate flick, pause and tick in all states, including mid-sequence and in KB.
REQ-032 After reset, the FSM SHALL not start without a new flick=1 sample.

Configuration
REQ-033 With BF_CTRL_PAUSE_EN defined: pause=1 SHALL suppress tick and hold the prescaler, counter and state, including the IDLE start.
REQ-034 With BF_CTRL_PAUSE_EN defined: pause SHALL not block rst.
REQ-035 With BF_CTRL_PAUSE_EN undefined: the pause port and its logic SHALL be absent; behaviour SHALL equal pause=0.

Verification (N_LAMPS=16, MID_LO=5, MID_HI=10, STEP_DIV=1 unless stated)
REQ-036 Full run: reset, one-cycle flick -> counter 0..10, 10..0, 0..16, 16..5, 5..16, 16..0; 74 ticks; done=1 for one cycle; then IDLE.
REQ-037 UP_B kickback: flick=1 with counter=10 in UP_B -> KB, counter 9..0, return to UP_B, 1..16, DN_B.
REQ-038 UP_C: flick at counter=5 ignored (counter->6); flick at 10 -> KB, 9..5, then UP_C 6..16.
REQ-039 STEP_DIV=3: counter changes every 3rd busy cycle; full run takes 1+74*3 cycles from flick to done.
REQ-040 Pause, macro defined: pause=1 for 20 cycles at counter=7 -> counter and state hold, then resume at 8. Macro undefined: port absent, same sequence as REQ-036.
REQ-041 rst pulse in DN_B at counter=12 -> next cycle state=0, counter=0, done=0, busy=0; stays idle until flick.
